sys_ctrl_burst: RTL
===================

# sys_ctrl_burst

Parametrised host-control engine for the NES emulator. It sits between the UART byte stream and the CPU memory bus, and handles host commands: halt, resume, status, CPU reset, and burst read/write of memory. The UART RX/TX wrappers sit outside the block. Every burst is acknowledged with an 8-bit checksum, and a mid-command inter-byte timeout returns the engine to idle.

## Interface
Parameters:
- ADDR_W, 16, bus address width; multiple of 8, 8..32; sent MSB byte first.
- TX_DEPTH, 16, response FIFO depth; power of two, ≥4.
- READ_LAT, 1, cycles from bus_re pulse to valid bus_rdata; 1..4.
- RST_CYCLES, 256, cpu_rst high duration in cycles.
- TIMEOUT_CYC, 1_000_000, max idle cycles between bytes of one command.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_valid  out  1  response byte available
- tx_data  out  8  response byte (FIFO head)
- tx_ready  in  1  UART TX accepts byte; transfer when tx_valid&&tx_ready
- bus_own  out  1  cpu_halt&&cpu_is_halted; top-level mux selects this block's bus signals
- bus_addr  out  ADDR_W  memory address
- bus_wdata  out  8  write data
- bus_we  out  1  one-cycle write strobe
- bus_re  out  1  one-cycle read strobe
- bus_rdata  in  8  read data
- cpu_halt  out  1  halt request
- cpu_rst  out  1  CPU reset, active-high
- cpu_is_halted  in  1  CPU acknowledges halt

## Operation
Opcodes, decoded in IDLE:
- 0x00: set cpu_halt=1.
- 0x01: set cpu_halt=0.
- 0x02: write burst.
- 0x03: read burst.
- 0x04: CPU reset.
- 0x05: status. Pushes {6'b0, cpu_is_halted, cpu_halt}.
- Any other opcode: push NAK 0x5A.

Burst frame:
- Frame is opcode, then ADDR_W/8 address bytes, then LEN. LEN=0 means 256 bytes.
- `granted` is latched at opcode receipt as cpu_halt&&cpu_is_halted.
- If `granted` is 0, all frame bytes are consumed (including write data), no bus strobes are issued, and the response is NAK 0x5A.

Write burst:
- Each data byte drives one bus_we pulse, with bus_addr and bus_wdata held that cycle.
- The address increments after each byte and wraps modulo 2^ADDR_W.
- After the last byte, push ACK 0xA5, then SUM.
- SUM is the 8-bit mod-256 sum of the data bytes.

Read burst:
- For each byte, pulse bus_re, wait READ_LAT cycles, sample bus_rdata and push it.
- Then increment and wrap the address as for writes.
- Before each bus_re, stall while the FIFO has fewer than 1 free entry.
- After N bytes, push ACK 0xA5, then SUM. The ACK/SUM pushes also stall on a full FIFO.
- rx bytes arriving during a read burst are discarded.

CPU reset:
- cpu_rst=1 for exactly RST_CYCLES cycles, then 0, then return to IDLE.
- cpu_halt is unchanged.
- Push ACK 0xA5 on completion.

States: IDLE, ADDR, LEN, WDATA, RD_ISSUE, RD_WAIT, RESP_ACK, RESP_SUM, RESP_NAK, RST_HOLD, STATUS.

Timeout:
- In ADDR, LEN or WDATA, a counter restarts on every rx_valid.
- When it reaches TIMEOUT_CYC, push 0xEE and go to IDLE with no further bus strobes.

## Timing
Reset values:
- All outputs are 0 during reset: tx_valid, bus_we, bus_re, cpu_halt, cpu_rst, bus_addr, bus_wdata.
- FIFO empty, state IDLE, SUM=0.

Reset mid-operation aborts immediately. There is no residual strobe and the FIFO is flushed.

Latencies:
- Opcode byte to cpu_halt change: 1 cycle.
- Last write data rx_valid to bus_we: 1 cycle.
- bus_re to FIFO push: READ_LAT+1 cycles.
- Read-burst throughput, FIFO not full: 1 byte per READ_LAT+2 cycles.
- FIFO push to tx_valid: 1 cycle when empty.

Handshake and FIFO rules:
- Push and pop in the same cycle are both honoured.
- tx_data is stable while tx_valid&&!tx_ready.
- Command processing never drops a response: a push into a full FIFO stalls the FSM.
- rx_valid is never stalled. An rx byte arriving while stalled on a push into a full FIFO is discarded. The host must not send during the response.

Address wrap: with ADDR_W=16, addr 0xFFFF and LEN 2 access 0xFFFF then 0x0000.

## Structure
- Package sys_ctrl_pkg: opcode constants, response codes (ACK 0xA5, NAK 0x5A, TIMEOUT 0xEE), state enum.
- Sub-module sys_ctrl_tx_fifo: synchronous byte FIFO, depth TX_DEPTH, with push/full/pop/empty, same clk/rst.
- The FSM, address counter, length counter, checksum and timeout counter live in the top.

## Test plan
- Status and halt: 0x05 → 0x00. 0x00, then assert cpu_is_halted, then 0x05 → 0x03. bus_own=1.
- Write burst, halted: 02 12 34 03 AA BB CC → bus_we at 0x1234/AA, 0x1235/BB, 0x1236/CC; response A5 31.
- Read burst, wrap, halted: memory preloaded with 0xFFFF=11, 0x0000=22; frame 03 FF FF 02 → 11 22 A5 33. Repeat with tx_ready held low until the FIFO fills: all bytes delivered in order, none lost.
- Denied write: not halted, 02 00 10 01 55 → no bus_we, response 5A, next opcode 0x05 decoded correctly.
- Timeout and bad opcode: 02 12 then silence for TIMEOUT_CYC → 0xEE, IDLE. Opcode 0x7F → 5A.
- Reset: 0x04 → cpu_rst high exactly RST_CYCLES cycles, then A5. Assert rst mid write burst → all outputs 0, FIFO empty, next 0x05 answered.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the host-control engine.
package sys_ctrl_pkg;

   localparam logic [7:0] OP_HALT   = 8'h00;
   localparam logic [7:0] OP_RESUME = 8'h01;
   localparam logic [7:0] OP_WRITE  = 8'h02;
   localparam logic [7:0] OP_READ   = 8'h03;
   localparam logic [7:0] OP_CPURST = 8'h04;
   localparam logic [7:0] OP_STATUS = 8'h05;

   localparam logic [7:0] CODE_ACK  = 8'hA5;
   localparam logic [7:0] CODE_NAK  = 8'h5A;
   localparam logic [7:0] CODE_TMO  = 8'hEE;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LEN,
      ST_WDATA,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_RESP_ACK,
      ST_RESP_SUM,
      ST_RESP_NAK,
      ST_RST_HOLD,
      ST_STATUS
   } state_e;

endpackage

// File: rtl/sys_ctrl_tx_fifo.sv
// Response byte FIFO; head is presented combinationally so tx_data holds while unpopped.
module sys_ctrl_tx_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   output logic       full,
   input  logic       pop,
   output logic [7:0] pop_data,
   output logic       empty
);
   import sys_ctrl_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CNT_MAX);
   assign empty    = (count_q == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr_q];

   // Pointer and occupancy update; simultaneous push and pop leave the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
   end

   // Storage array is not reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

   // Pointer/count registers; reset flushes the FIFO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sys_ctrl_burst.sv
// Host command engine: decodes UART bytes into halt/resume/status/reset and memory bursts.
module sys_ctrl_burst #(
   parameter int ADDR_W      = 16,
   parameter int TX_DEPTH    = 16,
   parameter int READ_LAT    = 1,
   parameter int RST_CYCLES  = 256,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              bus_own,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        bus_wdata,
   output logic              bus_we,
   output logic              bus_re,
   input  logic [7:0]        bus_rdata,
   output logic              cpu_halt,
   output logic              cpu_rst,
   input  logic              cpu_is_halted
);
   import sys_ctrl_pkg::*;

   localparam int ABYTES = ADDR_W / 8;
   localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int RST_W  = $clog2(RST_CYCLES + 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, bus_addr_q, bus_addr_d;
   logic [7:0]        bus_wdata_q, bus_wdata_d, sum_q, sum_d;
   logic              bus_we_q, bus_we_d, bus_re_q, bus_re_d;
   logic              cpu_halt_q, cpu_halt_d, cpu_rst_q, cpu_rst_d;
   logic              granted_q, granted_d, is_read_q, is_read_d, send_sum_q, send_sum_d;
   logic [8:0]        len_q, len_d;
   logic [2:0]        abyte_q, abyte_d, lat_q, lat_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;

   logic              fifo_push, fifo_full, fifo_empty, in_frame, timed_out, frame_rx;
   logic [7:0]        fifo_data;

   sys_ctrl_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (fifo_data),
      .full      (fifo_full),
      .pop       (tx_valid && tx_ready),
      .pop_data  (tx_data),
      .empty     (fifo_empty)
   );

   assign tx_valid  = !fifo_empty;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_we    = bus_we_q;
   assign bus_re    = bus_re_q;
   assign cpu_halt  = cpu_halt_q;
   assign cpu_rst   = cpu_rst_q;
   assign bus_own   = cpu_halt_q && cpu_is_halted;

   assign in_frame  = (state_q == ST_ADDR) || (state_q == ST_LEN) || (state_q == ST_WDATA);
   assign timed_out = (tmo_q == TMO_W'(TIMEOUT_CYC));
   assign frame_rx  = rx_valid && !timed_out;

   // Command FSM: next state, counters, checksum, strobes and response pushes.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_we_d    = 1'b0;
      bus_re_d    = 1'b0;
      cpu_halt_d  = cpu_halt_q;
      cpu_rst_d   = cpu_rst_q;
      granted_d   = granted_q;
      is_read_d   = is_read_q;
      send_sum_d  = send_sum_q;
      len_d       = len_q;
      sum_d       = sum_q;
      abyte_d     = abyte_q;
      lat_d       = lat_q;
      tmo_d       = tmo_q;
      rst_cnt_d   = rst_cnt_q;
      fifo_push   = 1'b0;
      fifo_data   = 8'h00;

      unique case (state_q)
         ST_IDLE: if (rx_valid) begin
            case (rx_data)
               OP_HALT:   cpu_halt_d = 1'b1;
               OP_RESUME: cpu_halt_d = 1'b0;
               OP_WRITE, OP_READ: begin
                  granted_d  = cpu_halt_q && cpu_is_halted;
                  is_read_d  = (rx_data == OP_READ);
                  send_sum_d = 1'b1;
                  sum_d      = 8'h00;
                  abyte_d    = 3'd0;
                  tmo_d      = '0;
                  state_d    = ST_ADDR;
               end
               OP_CPURST: begin
                  cpu_rst_d  = 1'b1;
                  rst_cnt_d  = '0;
                  send_sum_d = 1'b0;
                  state_d    = ST_RST_HOLD;
               end
               OP_STATUS: state_d = ST_STATUS;
               default:   state_d = ST_RESP_NAK;
            endcase
         end
         ST_ADDR: if (frame_rx) begin
            addr_d  = (addr_q << 8) | ADDR_W'(rx_data);
            abyte_d = abyte_q + 3'd1;
            if (abyte_q == 3'(ABYTES - 1)) state_d = ST_LEN;
         end
         ST_LEN: if (frame_rx) begin
            len_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
            if (is_read_q) state_d = granted_q ? ST_RD_ISSUE : ST_RESP_NAK;
            else           state_d = ST_WDATA;
         end
         ST_WDATA: if (frame_rx) begin
            if (granted_q) begin
               bus_we_d    = 1'b1;
               bus_addr_d  = addr_q;
               bus_wdata_d = rx_data;
               addr_d      = addr_q + ADDR_W'(1);
               sum_d       = sum_q + rx_data;
            end
            len_d = len_q - 9'd1;
            if (len_q == 9'd1) state_d = granted_q ? ST_RESP_ACK : ST_RESP_NAK;
         end
         ST_RD_ISSUE: if (!fifo_full) begin
            bus_re_d   = 1'b1;
            bus_addr_d = addr_q;
            lat_d      = 3'd0;
            state_d    = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            lat_d = lat_q + 3'd1;
            // A free slot was seen at issue and nothing else pushes meanwhile.
            if (lat_q == 3'(READ_LAT)) begin
               fifo_push = 1'b1;
               fifo_data = bus_rdata;
               sum_d     = sum_q + bus_rdata;
               addr_d    = addr_q + ADDR_W'(1);
               len_d     = len_q - 9'd1;
               state_d   = (len_q == 9'd1) ? ST_RESP_ACK : ST_RD_ISSUE;
            end
         end
         ST_RESP_ACK: if (!fifo_full) begin
            fifo_push = 1'b1;
            fifo_data = CODE_ACK;
            state_d   = send_sum_q ? ST_RESP_SUM : ST_IDLE;
         end
         ST_RESP_SUM: if (!fifo_full) begin
            fifo_push = 1'b1;
            fifo_data = sum_q;
            state_d   = ST_IDLE;
         end
         ST_RESP_NAK: if (!fifo_full) begin
            fifo_push = 1'b1;
            fifo_data = CODE_NAK;
            state_d   = ST_IDLE;
         end
         ST_RST_HOLD: begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
            if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
               cpu_rst_d = 1'b0;
               state_d   = ST_RESP_ACK;
            end
         end
         ST_STATUS: if (!fifo_full) begin
            fifo_push = 1'b1;
            fifo_data = {6'b0, cpu_is_halted, cpu_halt_q};
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Inter-byte timeout: saturates at the limit until the 0xEE code can be pushed.
      if (in_frame) begin
         if (timed_out) begin
            fifo_push = !fifo_full;
            fifo_data = CODE_TMO;
            if (!fifo_full) state_d = ST_IDLE;
         end else begin
            tmo_d = rx_valid ? '0 : tmo_q + TMO_W'(1);
         end
      end
   end

   // State and datapath registers; reset aborts any command with outputs cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_we_q    <= 1'b0;
         bus_re_q    <= 1'b0;
         cpu_halt_q  <= 1'b0;
         cpu_rst_q   <= 1'b0;
         granted_q   <= 1'b0;
         is_read_q   <= 1'b0;
         send_sum_q  <= 1'b0;
         len_q       <= '0;
         sum_q       <= '0;
         abyte_q     <= '0;
         lat_q       <= '0;
         tmo_q       <= '0;
         rst_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_we_q    <= bus_we_d;
         bus_re_q    <= bus_re_d;
         cpu_halt_q  <= cpu_halt_d;
         cpu_rst_q   <= cpu_rst_d;
         granted_q   <= granted_d;
         is_read_q   <= is_read_d;
         send_sum_q  <= send_sum_d;
         len_q       <= len_d;
         sum_q       <= sum_d;
         abyte_q     <= abyte_d;
         lat_q       <= lat_d;
         tmo_q       <= tmo_d;
         rst_cnt_q   <= rst_cnt_d;
      end
   end

endmodule
